uart_rx: RTL and testbench

- UART receiver; the companion to the team's transmitter at the far end of a serial link.
- Samples an asynchronous serial line with 1 start bit, DATA_BITS data bits (LSB first), 1 stop bit and no parity.
- Presents each good character on an AXI-Stream master with a one-word holding register.
- Flags framing and overrun errors as single-cycle pulses.

---
 rtl/uart_rx.sv | 156 +++++++++++++++
 tb/tb_uart_rx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 1 start, DATA_BITS data (LSB first), 1 stop, no parity.
// Characters are presented on an AXI-Stream master with a one-word holding register.
module uart_rx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 serial_data,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [DATA_BITS-1:0] m_axis_tdata,
  output logic                 framing_error,
  output logic                 overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CTR_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = $clog2(DATA_BITS + 1);

  localparam logic [CTR_W-1:0] HALF_M1  = CTR_W'(HALF - 1);
  localparam logic [CTR_W-1:0] LAST_CLK = CTR_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic                 r_sync1;
  logic                 r_sync2;
  logic [2:0]           r_hist;
  state_t               r_state;
  logic [CTR_W-1:0]     r_baud;
  logic [BIT_W-1:0]     r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_tvalid;
  logic [DATA_BITS-1:0] r_tdata;
  logic                 r_fe;
  logic                 r_ov;

  logic w_sample;
  logic w_baud_half;
  logic w_baud_last;

  assign w_sample    = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);
  assign w_baud_half = (r_baud == HALF_M1);
  assign w_baud_last = (r_baud == LAST_CLK);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_hist  <= 3'b111;
    end else begin
      r_sync1 <= serial_data;
      r_sync2 <= r_sync1;
      r_hist  <= {r_hist[1:0], r_sync2};
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_fe     <= 1'b0;
      r_ov     <= 1'b0;
    end else begin
      r_fe   <= 1'b0;
      r_ov   <= 1'b0;
      r_baud <= r_baud + CTR_W'(1);
      if (r_tvalid && m_axis_tready)
        r_tvalid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!r_sync2) begin
            r_state <= S_START;
            r_baud  <= '0;
          end
        end

        // Half-bit check rejects glitches and sets mid-bit alignment for DATA/STOP.
        S_START: begin
          if (w_baud_half) begin
            r_baud <= '0;
            if (w_sample) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DATA;
              r_bit   <= '0;
            end
          end
        end

        S_DATA: begin
          if (w_baud_last) begin
            r_baud  <= '0;
            r_shift <= {w_sample, r_shift[DATA_BITS-1:1]};
            if (r_bit == LAST_BIT) begin
              r_state <= S_STOP;
            end else begin
              r_bit <= r_bit + BIT_W'(1);
            end
          end
        end

        S_STOP: begin
          if (w_baud_last) begin
            r_baud <= '0;
            if (w_sample) begin
              r_state <= S_IDLE;
              if (!r_tvalid || m_axis_tready) begin
                r_tdata  <= r_shift;
                r_tvalid <= 1'b1;
              end else begin
                r_ov <= 1'b1;
              end
            end else begin
              r_fe    <= 1'b1;
              r_state <= S_BREAK;
            end
          end
        end

        // A held-low line must return high before another start can be seen.
        S_BREAK: begin
          if (r_sync2) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_baud  <= '0;
        end
      endcase
    end
  end

  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign framing_error = r_fe;
  assign overrun       = r_ov;

endmodule

// File: tb/tb_uart_rx.sv
// Directed + loopback bench for uart_rx at 10 clocks per bit, with a beat scoreboard.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       aresetn;
  logic       serial_data;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       framing_error;
  logic       overrun;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fe   = 0;
  int n_ov   = 0;
  int n_beat = 0;

  logic [7:0] sb[$];

  logic       prev_fe    = 1'b0;
  logic       prev_ov    = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  uart_rx #(
    .CLK_FREQ (1_000_000),
    .BAUD_RATE(100_000),
    .DATA_BITS(8)
  ) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .serial_data  (serial_data),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .framing_error(framing_error),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    serial_data = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      serial_data = d[i];
      wait_clks(CPB);
    end
    serial_data = stop_bit;
    wait_clks(CPB);
  endtask

  // Output monitor: pops the scoreboard on each handshake and checks pulse rules.
  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      n_beat++;
      check("beat_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) check("beat_tdata", {24'd0, m_axis_tdata}, {24'd0, sb.pop_front()});
    end
    if (aresetn && prev_stall && m_axis_tvalid)
      check("tdata_stable", {24'd0, m_axis_tdata}, {24'd0, prev_data});
    if (framing_error || overrun) begin
      check("fe_ov_exclusive", {31'd0, framing_error && overrun}, 32'd0);
      check("pulse_width", {31'd0, (framing_error && prev_fe) || (overrun && prev_ov)}, 32'd0);
    end
    if (framing_error) n_fe++;
    if (overrun) n_ov++;
    prev_fe    = framing_error;
    prev_ov    = overrun;
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
  end

  initial begin
    logic [7:0] r;
    aresetn       = 1'b0;
    serial_data   = 1'b1;
    m_axis_tready = 1'b1;
    #1;
    check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_tdata", {24'd0, m_axis_tdata}, 32'd0);
    check("rst_fe", {31'd0, framing_error}, 32'd0);
    check("rst_ov", {31'd0, overrun}, 32'd0);
    wait_clks(3);
    aresetn = 1'b1;
    wait_clks(20);

    // Single frame
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_clks(20);
    check("a5_drained", sb.size(), 0);
    check("a5_beats", n_beat, 1);

    // Back-to-back frames
    sb.push_back(8'h00);
    sb.push_back(8'hFF);
    sb.push_back(8'h5A);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h5A, 1'b1);
    wait_clks(20);
    check("b2b_drained", sb.size(), 0);
    check("b2b_beats", n_beat, 4);
    check("b2b_errors", n_fe + n_ov, 0);

    // Start-bit glitch
    serial_data = 1'b0;
    wait_clks(3);
    serial_data = 1'b1;
    wait_clks(40);
    check("glitch_beats", n_beat, 4);
    sb.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_clks(20);
    check("glitch_next_drained", sb.size(), 0);
    check("glitch_next_beats", n_beat, 5);

    // Framing error with held-low line
    send_frame(8'h55, 1'b0);
    wait_clks(20);
    serial_data = 1'b1;
    wait_clks(30);
    check("fe_count", n_fe, 1);
    check("fe_no_beat", n_beat, 5);
    sb.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    wait_clks(20);
    check("fe_next_drained", sb.size(), 0);
    check("fe_next_beats", n_beat, 6);
    check("fe_count_after", n_fe, 1);

    // Overrun with a stalled sink
    m_axis_tready = 1'b0;
    sb.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    wait_clks(20);
    check("ov_count", n_ov, 1);
    check("ov_held_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    check("ov_held_tdata", {24'd0, m_axis_tdata}, 32'h12);
    m_axis_tready = 1'b1;
    wait_clks(5);
    check("ov_drained", sb.size(), 0);
    check("ov_beats", n_beat, 7);
    check("ov_tvalid_low", {31'd0, m_axis_tvalid}, 32'd0);

    // Reset mid-frame while a character is held
    m_axis_tready = 1'b0;
    send_frame(8'h77, 1'b1);
    wait_clks(5);
    check("pre_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    serial_data = 1'b0;
    wait_clks(CPB);
    serial_data = 1'b1;
    wait_clks(CPB);
    serial_data = 1'b0;
    wait_clks(CPB + 5);
    aresetn = 1'b0;
    #1;
    check("midrst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("midrst_tdata", {24'd0, m_axis_tdata}, 32'd0);
    wait_clks(2);
    serial_data = 1'b1;
    aresetn     = 1'b1;
    wait_clks(100);
    m_axis_tready = 1'b1;
    wait_clks(5);
    check("midrst_no_beat", n_beat, 7);
    sb.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    wait_clks(20);
    check("midrst_next_drained", sb.size(), 0);
    check("midrst_next_beats", n_beat, 8);

    // Loopback from a behavioural transmitter with random data
    for (int k = 0; k < 300; k++) begin
      r = 8'($urandom_range(0, 255));
      sb.push_back(r);
      send_frame(r, 1'b1);
      if (k % 50 == 0) wait_clks($urandom_range(0, 15));
    end
    wait_clks(20);
    check("loop_drained", sb.size(), 0);
    check("loop_beats", n_beat, 308);
    check("loop_fe", n_fe, 1);
    check("loop_ov", n_ov, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
